// File: rtl/sd_pkg.sv
// Shared types and constants for the SD card SPI-mode initialisation block.
package sd_pkg;

    typedef enum logic [2:0] {
        ST_POWERUP,
        ST_CMD0,
        ST_CMD8,
        ST_CMD55,
        ST_ACMD41,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        PH_SEND,
        PH_WAIT,
        PH_RECV,
        PH_GAP
    } phase_t;

    localparam logic [47:0] CMD0_FRAME   = 48'h40_0000_0000_95;
    localparam logic [47:0] CMD8_FRAME   = 48'h48_0000_01AA_87;
    localparam logic [47:0] CMD55_FRAME  = 48'h77_0000_0000_FF;
    localparam logic [47:0] ACMD41_FRAME = 48'h69_4000_0000_FF;

    localparam logic [11:0] CHECK_PATTERN = 12'h1AA;
    localparam logic [7:0]  R1_READY      = 8'h00;
    localparam logic [7:0]  R1_IDLE       = 8'h01;

    function automatic logic is_cmd(state_t s);
        return (s != ST_POWERUP) && (s != ST_DONE);
    endfunction

    function automatic logic [47:0] frame_of(state_t s);
        logic [47:0] f;
        case (s)
            ST_CMD8:   f = CMD8_FRAME;
            ST_CMD55:  f = CMD55_FRAME;
            ST_ACMD41: f = ACMD41_FRAME;
            default:   f = CMD0_FRAME;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/sd_init_clk_gen.sv
// SPI clock divider: sd_clk as a plain register, plus rise/fall strobes
// that are high in the clk_ref cycle whose edge toggles sd_clk.
module sd_spi_clk_gen #(
    parameter int CLK_DIV = 250
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic sd_clk,
    output logic rise,
    output logic fall
);

    localparam int W = $clog2(CLK_DIV);
    localparam logic [W-1:0] HALF_LAST = W'(CLK_DIV / 2 - 1);

    logic [W-1:0] cnt;
    logic         edge_now;

    assign edge_now = en && (cnt == HALF_LAST);
    assign rise     = edge_now && !sd_clk;
    assign fall     = edge_now && sd_clk;

    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            cnt    <= '0;
            sd_clk <= 1'b0;
        end else if (edge_now) begin
            cnt    <= '0;
            sd_clk <= !sd_clk;
        end else begin
            cnt    <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/sd_init.sv
// SD card SPI-mode power-up and initialisation sequencer
// (CMD0, CMD8, CMD55/ACMD41 loop) driving a divided SPI clock.
module sd_init
    import sd_pkg::*;
#(
    parameter int CLK_DIV      = 250,
    parameter int POWERUP_CLKS = 80,
    parameter int RESP_TIMEOUT = 64
) (
    input  logic clk_ref,
    input  logic rst_n,
    input  logic sd_miso,
    output logic sd_clk,
    output logic sd_cs,
    output logic sd_mosi,
    output logic sd_init_done
);

    localparam logic [15:0] PU_LAST    = 16'(POWERUP_CLKS - 1);
    localparam logic [15:0] TO_LAST    = 16'(RESP_TIMEOUT - 1);
    localparam logic [15:0] FRAME_BITS = 16'd48;
    localparam logic [15:0] GAP_LAST   = 16'd7;

    state_t      state, state_n;
    phase_t      phase, phase_n;
    logic [15:0] cnt, cnt_n;
    logic [47:0] tx, tx_n;
    logic [39:0] rx, rx_n;
    logic [15:0] rx_len;
    logic        cs_d, mosi_d, done_d;
    logic        clk_en, rise, fall;

    sd_spi_clk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_gen (
        .clk   (clk_ref),
        .rst_n (rst_n),
        .en    (clk_en),
        .sd_clk(sd_clk),
        .rise  (rise),
        .fall  (fall)
    );

    // CMD8 answers with R7: R1 followed by a 32-bit echo
    assign rx_len = (state == ST_CMD8) ? 16'd40 : 16'd8;

    function automatic state_t decide(state_t s, logic [39:0] r);
        logic [7:0] r1;
        state_t     nxt;
        r1  = (s == ST_CMD8) ? r[39:32] : r[7:0];
        nxt = ST_CMD0;
        case (s)
            ST_CMD0:
                if (r1 == R1_IDLE) nxt = ST_CMD8;
            ST_CMD8:
                if (r1 == R1_IDLE && r[11:0] == CHECK_PATTERN)
                    nxt = ST_CMD55;
            ST_CMD55:
                if (r1 == R1_IDLE || r1 == R1_READY)
                    nxt = ST_ACMD41;
            ST_ACMD41:
                if (r1 == R1_READY) nxt = ST_DONE;
                else if (r1 == R1_IDLE) nxt = ST_CMD55;
            default:
                nxt = ST_CMD0;
        endcase
        return nxt;
    endfunction

    always_ff @(posedge clk_ref) begin
        if (!rst_n) begin
            state        <= ST_POWERUP;
            phase        <= PH_SEND;
            cnt          <= '0;
            tx           <= '0;
            rx           <= '0;
            sd_cs        <= 1'b1;
            sd_mosi      <= 1'b1;
            sd_init_done <= 1'b0;
        end else begin
            state        <= state_n;
            phase        <= phase_n;
            cnt          <= cnt_n;
            tx           <= tx_n;
            rx           <= rx_n;
            sd_cs        <= cs_d;
            sd_mosi      <= mosi_d;
            sd_init_done <= done_d;
        end
    end

    always_comb begin
        state_n = state;
        phase_n = phase;
        cnt_n   = cnt;
        tx_n    = tx;
        rx_n    = rx;
        if (state == ST_POWERUP) begin
            if (fall) begin
                if (cnt == PU_LAST) begin
                    state_n = ST_CMD0;
                    phase_n = PH_SEND;
                    cnt_n   = '0;
                    tx_n    = frame_of(ST_CMD0);
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
        end else if (is_cmd(state)) begin
            unique case (phase)
                PH_SEND: begin
                    if (fall) begin
                        if (cnt == FRAME_BITS) begin
                            phase_n = PH_WAIT;
                            cnt_n   = '0;
                            rx_n    = '0;
                        end else begin
                            tx_n  = {tx[46:0], 1'b1};
                            cnt_n = cnt + 16'd1;
                        end
                    end
                end
                PH_WAIT: begin
                    if (rise && !sd_miso) begin
                        phase_n = PH_RECV;
                        rx_n    = {rx[38:0], 1'b0};
                        cnt_n   = 16'd1;
                    end else if (fall) begin
                        if (cnt == TO_LAST) begin
                            phase_n = PH_GAP;
                            cnt_n   = '0;
                        end else begin
                            cnt_n = cnt + 16'd1;
                        end
                    end
                end
                PH_RECV: begin
                    if (rise && cnt != rx_len) begin
                        rx_n  = {rx[38:0], sd_miso};
                        cnt_n = cnt + 16'd1;
                    end else if (fall && cnt == rx_len) begin
                        state_n = decide(state, rx);
                        phase_n = PH_GAP;
                        cnt_n   = '0;
                    end
                end
                PH_GAP: begin
                    if (fall) begin
                        if (cnt == GAP_LAST) begin
                            phase_n = PH_SEND;
                            cnt_n   = '0;
                            tx_n    = frame_of(state);
                        end else begin
                            cnt_n = cnt + 16'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // cs/mosi only move on fall strobes; the first SEND fall leaves mosi high
    always_comb begin
        clk_en = (state != ST_DONE);
        cs_d   = sd_cs;
        mosi_d = sd_mosi;
        if (fall) begin
            cs_d   = !(is_cmd(state_n) && phase_n != PH_GAP);
            mosi_d = (is_cmd(state) && phase == PH_SEND
                      && cnt != FRAME_BITS) ? tx[47] : 1'b1;
        end
        done_d = (state_n == ST_DONE);
    end

endmodule

// File: tb/tb_sd_init.sv
// Directed bench for sd_init with a behavioural SPI-mode card model.
module tb_sd_init;

    logic clk_ref = 1'b0;
    logic rst_n   = 1'b0;
    logic sd_miso = 1'b0;
    logic sd_clk, sd_cs, sd_mosi, sd_init_done;

    always #5 clk_ref = ~clk_ref;

    sd_init #(
        .CLK_DIV     (4),
        .POWERUP_CLKS(80),
        .RESP_TIMEOUT(64)
    ) dut (
        .clk_ref     (clk_ref),
        .rst_n       (rst_n),
        .sd_miso     (sd_miso),
        .sd_clk      (sd_clk),
        .sd_cs       (sd_cs),
        .sd_mosi     (sd_mosi),
        .sd_init_done(sd_init_done)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [47:0] full_frame(logic [7:0] c);
        logic [47:0] f;
        case (c)
            8'h40:   f = 48'h400000000095;
            8'h48:   f = 48'h48000001AA87;
            8'h77:   f = 48'h7700000000FF;
            8'h69:   f = 48'h6940000000FF;
            default: f = 48'h0;
        endcase
        return f;
    endfunction

    // card model state
    logic        sclk_q     = 1'b0;
    logic        collecting = 1'b0;
    int          col_cnt    = 0;
    logic [47:0] sr         = '0;
    logic [47:0] frames[$];
    int          first_rise[$];
    int          last_rise[$];
    int          gap_q[$];
    int          lead_q[$];
    bit          resp_q[$];
    int          rise_idx    = 0;
    int          cs_high_cnt = 0;
    int          lead_cnt    = 0;
    int          bad_mosi    = 0;
    bit          silent_cmd0 = 1'b0;
    int          acmd_busy   = 0;
    logic [31:0] echo        = 32'h1AA;

    task automatic queue_resp(logic [39:0] data, int nbits);
        repeat (8) resp_q.push_back(1'b1);
        for (int i = nbits - 1; i >= 0; i--) resp_q.push_back(data[i]);
    endtask

    task automatic respond(logic [47:0] f);
        case (f[47:40])
            8'h40: if (!silent_cmd0) queue_resp(40'h01, 8);
            8'h48: queue_resp({8'h01, echo}, 40);
            8'h77: queue_resp(40'h01, 8);
            8'h69: begin
                if (acmd_busy > 0) begin
                    acmd_busy--;
                    queue_resp(40'h01, 8);
                end else begin
                    queue_resp(40'h00, 8);
                end
            end
            default: ;
        endcase
    endtask

    always @(posedge clk_ref) begin
        #1;
        if (sd_clk && !sclk_q) begin
            rise_idx++;
            if (sd_cs) begin
                cs_high_cnt++;
                lead_cnt   = 0;
                collecting = 1'b0;
                resp_q.delete();
                if (!sd_mosi) bad_mosi++;
            end else if (!collecting) begin
                if (!sd_mosi) begin
                    collecting = 1'b1;
                    col_cnt    = 1;
                    sr         = '0;
                    first_rise.push_back(rise_idx);
                    gap_q.push_back(cs_high_cnt);
                    lead_q.push_back(lead_cnt);
                end else begin
                    lead_cnt++;
                end
            end else begin
                sr = {sr[46:0], sd_mosi};
                col_cnt++;
                if (col_cnt == 48) begin
                    collecting  = 1'b0;
                    frames.push_back(sr);
                    last_rise.push_back(rise_idx);
                    cs_high_cnt = 0;
                    lead_cnt    = 0;
                    respond(sr);
                end
            end
        end
        if (!sd_clk && sclk_q) begin
            if (resp_q.size() > 0) sd_miso = resp_q.pop_front();
            else sd_miso = sd_cs ? 1'b0 : 1'b1;
        end
        sclk_q = sd_clk;
    end

    task automatic reset_card();
        frames.delete();
        first_rise.delete();
        last_rise.delete();
        gap_q.delete();
        lead_q.delete();
        resp_q.delete();
        collecting  = 1'b0;
        col_cnt     = 0;
        rise_idx    = 0;
        cs_high_cnt = 0;
        lead_cnt    = 0;
        bad_mosi    = 0;
    endtask

    task automatic apply_reset(string tag);
        @(negedge clk_ref);
        rst_n = 1'b0;
        @(posedge clk_ref);
        @(posedge clk_ref);
        #1;
        check({tag, " rst sd_clk"}, 64'(sd_clk), 64'd0);
        check({tag, " rst sd_cs"}, 64'(sd_cs), 64'd1);
        check({tag, " rst sd_mosi"}, 64'(sd_mosi), 64'd1);
        check({tag, " rst done"}, 64'(sd_init_done), 64'd0);
        @(negedge clk_ref);
        reset_card();
        rst_n = 1'b1;
    endtask

    task automatic wait_frames(int n, string tag);
        int t = 0;
        while (frames.size() < n && t < 30000) begin
            @(posedge clk_ref);
            t++;
        end
        #2;
        check({tag, " frames seen"}, 64'(frames.size() >= n), 64'd1);
    endtask

    task automatic wait_done(string tag);
        int t = 0;
        while (!sd_init_done && t < 3000) begin
            @(posedge clk_ref);
            t++;
        end
        #2;
        check({tag, " done reached"}, 64'(sd_init_done), 64'd1);
    endtask

    typedef struct {
        bit             silent;
        int             busy;
        logic [31:0]    echo;
        int             n;
        bit             exp_done;
        logic [9:0][7:0] cmds;
    } vec_t;

    vec_t vecs[4];

    initial begin
        string       tag;
        logic [47:0] act;
        int          n69;
        int          highs;
        int          t;

        vecs[0].silent   = 1'b0;
        vecs[0].busy     = 0;
        vecs[0].echo     = 32'h000001AA;
        vecs[0].n        = 4;
        vecs[0].exp_done = 1'b1;
        vecs[0].cmds     = '0;
        vecs[0].cmds[0]  = 8'h40;
        vecs[0].cmds[1]  = 8'h48;
        vecs[0].cmds[2]  = 8'h77;
        vecs[0].cmds[3]  = 8'h69;

        vecs[1].silent   = 1'b0;
        vecs[1].busy     = 3;
        vecs[1].echo     = 32'h000001AA;
        vecs[1].n        = 10;
        vecs[1].exp_done = 1'b1;
        vecs[1].cmds     = '0;
        vecs[1].cmds[0]  = 8'h40;
        vecs[1].cmds[1]  = 8'h48;
        for (int k = 0; k < 4; k++) begin
            vecs[1].cmds[2 + 2 * k] = 8'h77;
            vecs[1].cmds[3 + 2 * k] = 8'h69;
        end

        vecs[2].silent   = 1'b0;
        vecs[2].busy     = 0;
        vecs[2].echo     = 32'h000001AB;
        vecs[2].n        = 3;
        vecs[2].exp_done = 1'b0;
        vecs[2].cmds     = '0;
        vecs[2].cmds[0]  = 8'h40;
        vecs[2].cmds[1]  = 8'h48;
        vecs[2].cmds[2]  = 8'h40;

        vecs[3].silent   = 1'b1;
        vecs[3].busy     = 0;
        vecs[3].echo     = 32'h000001AA;
        vecs[3].n        = 3;
        vecs[3].exp_done = 1'b0;
        vecs[3].cmds     = '0;
        vecs[3].cmds[0]  = 8'h40;
        vecs[3].cmds[1]  = 8'h40;
        vecs[3].cmds[2]  = 8'h40;

        for (int v = 0; v < 4; v++) begin
            tag = $sformatf("v%0d", v);
            silent_cmd0 = vecs[v].silent;
            acmd_busy   = vecs[v].busy;
            echo        = vecs[v].echo;
            apply_reset(tag);
            wait_frames(vecs[v].n, tag);
            if (vecs[v].exp_done) begin
                wait_done(tag);
                highs = 0;
                repeat (200) begin
                    @(posedge clk_ref);
                    #1;
                    if (sd_clk) highs++;
                end
                check({tag, " done sticky"}, 64'(sd_init_done), 64'd1);
                check({tag, " done cs"}, 64'(sd_cs), 64'd1);
                check({tag, " done mosi"}, 64'(sd_mosi), 64'd1);
                check({tag, " done sd_clk highs"}, 64'(highs), 64'd0);
                check({tag, " frame count"}, 64'(frames.size()),
                      64'(vecs[v].n));
            end else begin
                check({tag, " not done"}, 64'(sd_init_done), 64'd0);
            end
            for (int k = 0; k < vecs[v].n; k++) begin
                act = (k < frames.size()) ? frames[k] : 48'h0;
                check($sformatf("%s frame%0d", tag, k), 64'(act),
                      64'(full_frame(vecs[v].cmds[k])));
                if (k < lead_q.size())
                    check($sformatf("%s lead%0d", tag, k),
                          64'(lead_q[k]), 64'd1);
                if (k >= 1 && k < gap_q.size())
                    check($sformatf("%s gap%0d", tag, k),
                          64'(gap_q[k]), 64'd8);
            end
            check({tag, " powerup pulses"},
                  64'(gap_q.size() > 0 ? gap_q[0] : -1), 64'd80);
            check({tag, " mosi high while cs high"}, 64'(bad_mosi), 64'd0);
            if (v == 1) begin
                n69 = 0;
                foreach (frames[i]) if (frames[i][47:40] == 8'h69) n69++;
                check({tag, " acmd41 count"}, 64'(n69), 64'd4);
            end
            if (v == 3) begin
                check({tag, " resend spacing"},
                      64'((first_rise.size() > 1 && last_rise.size() > 0)
                          ? first_rise[1] - last_rise[0] : -1), 64'd74);
            end
        end

        // reset pulse in the middle of CMD8
        silent_cmd0 = 1'b0;
        acmd_busy   = 0;
        echo        = 32'h000001AA;
        apply_reset("mid");
        t = 0;
        while (!(frames.size() == 1 && collecting && col_cnt >= 10)
               && t < 5000) begin
            @(posedge clk_ref);
            t++;
        end
        #2;
        check("mid reached cmd8", 64'(t < 5000), 64'd1);
        check("mid cs low before reset", 64'(sd_cs), 64'd0);
        @(negedge clk_ref);
        rst_n = 1'b0;
        @(posedge clk_ref);
        #1;
        check("mid cs after reset edge", 64'(sd_cs), 64'd1);
        check("mid sd_clk after reset edge", 64'(sd_clk), 64'd0);
        check("mid mosi after reset edge", 64'(sd_mosi), 64'd1);
        @(posedge clk_ref);
        @(negedge clk_ref);
        reset_card();
        rst_n = 1'b1;
        wait_frames(2, "mid");
        check("mid powerup pulses",
              64'(gap_q.size() > 0 ? gap_q[0] : -1), 64'd80);
        check("mid frame0", 64'(frames.size() > 0 ? frames[0] : 48'h0),
              64'(48'h400000000095));
        check("mid frame1", 64'(frames.size() > 1 ? frames[1] : 48'h0),
              64'(48'h48000001AA87));
        wait_done("mid");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
